// File: rtl/fetch_pipe_if.sv
// Instruction-memory port of the Y86-64 fetch stage: fetch address out, 10 raw bytes and error flag back.
interface fetch_pipe_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0] imem_addr;
  logic [79:0]       imem_bytes;
  logic              imem_error;

  modport master (output imem_addr, input imem_bytes, input imem_error);
  modport slave  (input imem_addr, output imem_bytes, output imem_error);
endinterface

// File: rtl/fetch_pipe.sv
// Y86-64 fetch stage with F (predicted PC) and D pipeline registers.
// Optional FETCH_HALT_HOLD_EN: freeze F once a HLT/ADR/INS fetch is registered into D.
module fetch_pipe #(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [DATA_W-1:0] W_valM,
  fetch_pipe_if.master      imem,
  output logic [DATA_W-1:0] f_predPC,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [DATA_W-1:0] D_valC,
  output logic [DATA_W-1:0] D_valP
);

  localparam int unsigned DW = DATA_W;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [DW-1:0] f_pc;
  logic [3:0]    f_icode;
  logic [3:0]    f_ifun;
  logic [3:0]    f_ra;
  logic [3:0]    f_rb;
  logic [DW-1:0] f_valc;
  logic [DW-1:0] f_valp;
  logic [DW-1:0] f_pred;
  logic [2:0]    f_stat;
  logic [63:0]   valc_raw;
  logic          need_regids;
  logic          need_valc;
  logic          instr_valid;
  logic          f_hold;

  // PC select: mispredicted jXX recovery beats ret return address.
  always_comb begin
    f_pc = f_predPC;
    if (M_icode == I_JXX && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end
  end

  assign imem.imem_addr = f_pc;

  // A faulting fetch is presented to decode as a nop so nothing downstream acts on it.
  assign f_icode = imem.imem_error ? I_NOP : imem.imem_bytes[7:4];
  assign f_ifun  = imem.imem_error ? 4'h0  : imem.imem_bytes[3:0];

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    instr_valid = 1'b0;
    case (f_icode)
      I_HALT, I_NOP, I_RET:  instr_valid = (f_ifun == 4'h0);
      I_RRMOVQ: begin
        need_regids = 1'b1;
        instr_valid = (f_ifun <= 4'h6);
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
        instr_valid = (f_ifun == 4'h0);
      end
      I_OPQ: begin
        need_regids = 1'b1;
        instr_valid = (f_ifun <= 4'h3);
      end
      I_JXX: begin
        need_valc   = 1'b1;
        instr_valid = (f_ifun <= 4'h6);
      end
      I_CALL: begin
        need_valc   = 1'b1;
        instr_valid = (f_ifun == 4'h0);
      end
      I_PUSHQ, I_POPQ: begin
        need_regids = 1'b1;
        instr_valid = (f_ifun == 4'h0);
      end
      default: instr_valid = 1'b0;
    endcase
  end

  assign f_ra     = need_regids ? imem.imem_bytes[15:12] : R_NONE;
  assign f_rb     = need_regids ? imem.imem_bytes[11:8]  : R_NONE;
  assign valc_raw = need_regids ? imem.imem_bytes[79:16] : imem.imem_bytes[71:8];
  assign f_valc   = need_valc ? DW'(valc_raw) : '0;
  assign f_valp   = f_pc + DW'(1) + DW'(need_regids) + (need_valc ? DW'(8) : DW'(0));
  assign f_pred   = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;

  always_comb begin
    f_stat = S_AOK;
    if (imem.imem_error) begin
      f_stat = S_ADR;
    end else if (!instr_valid) begin
      f_stat = S_INS;
    end else if (f_icode == I_HALT) begin
      f_stat = S_HLT;
    end
  end

`ifdef FETCH_HALT_HOLD_EN
  logic halted;

  // Sticky until reset: set when an exceptional fetch actually lands in D.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (!D_stall && !D_bubble && f_stat != S_AOK) begin
      halted <= 1'b1;
    end
  end

  assign f_hold = F_stall | halted;
`else
  assign f_hold = F_stall;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      f_predPC <= RESET_PC;
    end else if (!f_hold) begin
      f_predPC <= f_pred;
    end
  end

  // D register: stall has priority over bubble.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      D_stat  <= S_AOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      D_rA    <= R_NONE;
      D_rB    <= R_NONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      if (D_bubble) begin
        D_stat  <= S_AOK;
        D_icode <= I_NOP;
        D_ifun  <= 4'h0;
        D_rA    <= R_NONE;
        D_rB    <= R_NONE;
        D_valC  <= '0;
        D_valP  <= '0;
      end else begin
        D_stat  <= f_stat;
        D_icode <= f_icode;
        D_ifun  <= f_ifun;
        D_rA    <= f_ra;
        D_rB    <= f_rb;
        D_valC  <= f_valc;
        D_valP  <= f_valp;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// Scoreboard bench for fetch_pipe: directed program fragments, then randomized fetch traffic
// against a table-driven Y86-64 fetch model.
module tb_fetch_pipe;

  localparam int unsigned DW = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } dreg_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] fpred;
    dreg_t       d;
  } exp_t;

  localparam dreg_t BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                               valc: 64'h0, valp: 64'h0};

  // Instruction length in bytes and largest legal ifun, indexed by icode; icodes C..F are illegal.
  int unsigned len_tab  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int unsigned ifun_max [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0};

  logic        clock = 1'b0;
  logic        rst_n;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [63:0] f_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  fetch_pipe_if #(.DATA_W(DW)) imem_if ();

  fetch_pipe #(.DATA_W(DW), .RESET_PC(RESET_PC)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valA   (M_valA),
    .W_icode  (W_icode),
    .W_valM   (W_valM),
    .imem     (imem_if.master),
    .f_predPC (f_predPC),
    .D_stat   (D_stat),
    .D_icode  (D_icode),
    .D_ifun   (D_ifun),
    .D_rA     (D_rA),
    .D_rB     (D_rB),
    .D_valC   (D_valC),
    .D_valP   (D_valP)
  );

  always #5 clock = ~clock;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_f;
  dreg_t       m_d;
  bit          m_halt;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference fetch: decode one instruction from its byte image using the length/ifun tables.
  function automatic void ref_fetch(input logic [63:0] pc, input logic [79:0] bytes, input logic err,
                                    output dreg_t d, output logic [63:0] pred);
    logic [7:0]  b [10];
    logic [3:0]  ic, fn;
    int unsigned len, off;
    bit          has_reg;
    for (int i = 0; i < 10; i++) b[i] = bytes[8*i +: 8];
    ic      = err ? 4'h1 : b[0][7:4];
    fn      = err ? 4'h0 : b[0][3:0];
    len     = len_tab[ic];
    has_reg = (len == 2 || len == 10);
    off     = has_reg ? 2 : 1;
    d.icode = ic;
    d.ifun  = fn;
    d.ra    = has_reg ? b[1][7:4] : 4'hF;
    d.rb    = has_reg ? b[1][3:0] : 4'hF;
    d.valc  = 64'h0;
    if (len >= 9) for (int k = 0; k < 8; k++) d.valc[8*k +: 8] = b[off + k];
    d.valp  = pc + 64'(len);
    if (err)                                   d.stat = 3'd3;
    else if (ic > 4'hB || fn > ifun_max[ic])   d.stat = 3'd4;
    else if (ic == 4'h0)                       d.stat = 3'd2;
    else                                       d.stat = 3'd1;
    pred = (ic == 4'h7 || ic == 4'h8) ? d.valc : d.valp;
  endfunction

  // Drive one cycle of inputs at the falling edge and push what the DUT must show this cycle.
  task automatic step(input bit rst, input bit fst, input bit dst, input bit dbub,
                      input logic [3:0] mic, input bit mc, input logic [63:0] mva,
                      input logic [3:0] wic, input logic [63:0] wvm,
                      input logic [79:0] bytes, input bit err);
    exp_t        e;
    dreg_t       d;
    logic [63:0] pc, pred;
    @(negedge clock);
    rst_n = rst; F_stall = fst; D_stall = dst; D_bubble = dbub;
    M_icode = mic; M_Cnd = mc; M_valA = mva; W_icode = wic; W_valM = wvm;
    imem_if.imem_bytes = bytes; imem_if.imem_error = err;
    if (!rst) begin
      m_f = RESET_PC; m_d = BUBBLE; m_halt = 1'b0;
    end
    if (mic == 4'h7 && !mc) pc = mva;
    else if (wic == 4'h9)   pc = wvm;
    else                    pc = m_f;
    ref_fetch(pc, bytes, err, d, pred);
    e.addr = pc; e.fpred = m_f; e.d = m_d;
    sb_q.push_back(e);
    if (rst) begin
      if (!fst && !m_halt) m_f = pred;
`ifdef FETCH_HALT_HOLD_EN
      if (!dst && !dbub && d.stat != 3'd1) m_halt = 1'b1;
`endif
      if (!dst) m_d = dbub ? BUBBLE : d;
    end
  endtask

  task automatic plain(input logic [79:0] bytes, input bit err);
    step(1, 0, 0, 0, 4'h0, 1, 64'h0, 4'h0, 64'h0, bytes, err);
  endtask

  // Monitor: outputs are stable 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("imem_addr", imem_if.imem_addr, e.addr);
        chk("f_predPC",  f_predPC,          e.fpred);
        chk("D_stat",    64'(D_stat),       64'(e.d.stat));
        chk("D_icode",   64'(D_icode),      64'(e.d.icode));
        chk("D_ifun",    64'(D_ifun),       64'(e.d.ifun));
        chk("D_rA",      64'(D_rA),         64'(e.d.ra));
        chk("D_rB",      64'(D_rB),         64'(e.d.rb));
        chk("D_valC",    D_valC,            e.d.valc);
        chk("D_valP",    D_valP,            e.d.valp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic [79:0] nop_b, irm_b, jxx_b, bytes;
    logic [95:0] r;
    logic [3:0]  ic, mic, wic;
    rst_n = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_icode = 4'h0; M_Cnd = 1'b1; M_valA = '0; W_icode = 4'h0; W_valM = '0;
    imem_if.imem_bytes = '0; imem_if.imem_error = 1'b0;
    m_f = RESET_PC; m_d = BUBBLE; m_halt = 1'b0;

    nop_b = {10{8'h10}};
    irm_b = {64'h2A382812, 8'hF2, 8'h30};
    jxx_b = {8'h00, 64'h100, 8'h74};

    // Reset, then sequential nops.
    step(0, 0, 0, 0, 4'h0, 1, 64'h0, 4'h0, 64'h0, nop_b, 0);
    step(0, 0, 0, 0, 4'h0, 1, 64'h0, 4'h0, 64'h0, nop_b, 0);
    repeat (4) plain(nop_b, 0);
    // ret redirect to 0x10 carrying irmovq, then to 0x20 carrying jXX to 0x100.
    step(1, 0, 0, 0, 4'h0, 1, 64'h0, 4'h9, 64'h10, irm_b, 0);
    step(1, 0, 0, 0, 4'h0, 1, 64'h0, 4'h9, 64'h20, jxx_b, 0);
    // Mispredict recovery to 0x29; jXX beats ret when both present; ret alone.
    step(1, 0, 0, 0, 4'h7, 0, 64'h29, 4'h0, 64'h0, nop_b, 0);
    step(1, 0, 0, 0, 4'h7, 0, 64'h29, 4'h9, 64'h55, nop_b, 0);
    step(1, 0, 0, 0, 4'h7, 1, 64'h29, 4'h9, 64'h55, irm_b, 0);
    plain(nop_b, 0);
    // Stall beats bubble for two cycles, then bubble alone.
    step(1, 0, 1, 1, 4'h0, 1, 64'h0, 4'h0, 64'h0, irm_b, 0);
    step(1, 0, 1, 1, 4'h0, 1, 64'h0, 4'h0, 64'h0, irm_b, 0);
    step(1, 0, 0, 1, 4'h0, 1, 64'h0, 4'h0, 64'h0, irm_b, 0);
    step(1, 1, 0, 0, 4'h0, 1, 64'h0, 4'h0, 64'h0, nop_b, 0);
    plain(nop_b, 0);
    // Exceptional fetches: illegal icode, memory error, halt, then nops while frozen (or not).
    plain({72'h0, 8'hC0}, 0);
    plain(irm_b, 1);
    plain({72'h0, 8'h00}, 0);
    repeat (6) plain(nop_b, 0);

    // Randomized traffic with occasional resets.
    step(0, 0, 0, 0, 4'h0, 1, 64'h0, 4'h0, 64'h0, nop_b, 0);
    for (int n = 0; n < 3000; n++) begin
      r = {$urandom(), $urandom(), $urandom()};
      bytes = r[79:0];
      ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      bytes[7:0] = {ic, 4'($urandom_range(0, 7) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 6))};
      if ($urandom_range(0, 3) == 0) bytes[7:0] = 8'h10;
      mic = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      wic = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 60) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, mic, 1'($urandom_range(0, 1)),
           {$urandom(), $urandom()}, wic, {$urandom(), $urandom()}, bytes,
           $urandom_range(0, 15) == 0);
    end

    @(negedge clock);
    #3;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pipe.md
Name: fetch_pipe

Overview:
Y86-64 pipelined fetch stage plus F and D pipeline registers; sits directly upstream of decode and feeds it icode/ifun/rA/rB, valC and valP.
- Selects the next PC: predicted PC, mispredicted-branch recovery, or ret return address.
- Splits the instruction bytes into fields and computes valP and predPC.
- Applies stall/bubble pipeline control from the hazard unit.
- Instruction memory is external and combinational.

Parameters:
RESET_PC, 64'h0, value loaded into F_predPC on reset
DATA_W, 64, width of PC/valC/valP/valA/valM

Ports:
clock  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
F_stall  in  1  hold F_predPC
D_stall  in  1  hold D register
D_bubble  in  1  load nop into D register
M_icode  in  4  icode in memory stage
M_Cnd  in  1  branch condition in memory stage
M_valA  in  DATA_W  fall-through PC of mispredicted jXX
W_icode  in  4  icode in writeback stage
W_valM  in  DATA_W  return address of ret
imem_addr  out  DATA_W  selected fetch PC (f_pc)
imem_bytes  in  80  10 instruction bytes; byte0 = [7:0], little-endian
imem_error  in  1  fetch address invalid
f_predPC  out  DATA_W  current F register contents
D_stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
D_icode, D_ifun, D_rA, D_rB  out  4 each  decoded fields
D_valC  out  DATA_W  constant word
D_valP  out  DATA_W  next sequential PC

Behaviour:
- Reset, asynchronous, rst_n low:
  - F_predPC = RESET_PC.
  - D loads the bubble: stat=1, icode=1, ifun=0, rA=rB=4'hF, valC=0, valP=0.
  - Release is synchronous to the next rising edge.
- PC select, combinational; first match wins:
  - M_icode==7 and !M_Cnd -> M_valA
  - W_icode==9 -> W_valM
  - else F_predPC
- Field split:
  - icode = byte0[7:4], ifun = byte0[3:0].
  - need_regids for icode in {2,3,4,5,6,A,B}; need_valC for icode in {3,4,5,7,8}.
  - rA = byte1[7:4], rB = byte1[3:0] if need_regids, else both 4'hF.
  - valC = bytes 2..9 if need_regids, else bytes 1..8; otherwise 0.
- valP = f_pc + 1 + need_regids + 8*need_valC, modulo 2^64, wrap permitted.
- Instruction validity:
  - Invalid if icode > B.
  - Invalid if ifun != 0 for icodes 0,1,3,4,5,8,9,A,B.
  - Invalid if ifun > 6 for icodes 2,7.
  - Invalid if ifun > 3 for icode 6.
- Status priority:
  - imem_error -> ADR, and icode/ifun forced to 1/0.
  - else invalid -> INS.
  - else icode==0 -> HLT.
  - else AOK.
- predPC = valC for icode 7 or 8, else valP.
- F register, at rising edge:
  - F_stall -> hold.
  - else load predPC.
- D register, at rising edge:
  - D_stall -> hold (stall beats bubble when both asserted).
  - else D_bubble -> load the bubble.
  - else load f_stat, icode, ifun, rA, rB, valC, valP.
- Latency:
  - PC-to-D outputs is 1 cycle.
  - Recovery: the PC selected from M_valA/W_valM appears on imem_addr in the same cycle, reaches D the following edge.

Optional Feature:
FETCH_HALT_HOLD_EN
- Defined: once a fetch with f_stat HLT, ADR or INS is registered into D (not stalled), the F register freezes. F_predPC is held and predPC is ignored until reset, so no bytes past halt are fetched; recovery selects still drive imem_addr.
- Undefined: fetch continues sequentially past halt/error, per the standard PIPE model; downstream stages squash.

Test Plan:
1. Reset, RESET_PC=0x0, bytes 0x10 (nop) repeated, 3 edges -> D_icode=1, D_valP=0x1,0x2,0x3; f_predPC tracks.
2. irmovq 0x30 0xF2 with valC 0x2A382812 at PC 0x10 -> D_rA=F, D_rB=2, D_valC=0x2A382812, D_valP=0x1A, stat=1.
3. jXX 0x74 dest 0x100 at PC 0x20 -> f_predPC=0x100. Next cycle drive M_icode=7, M_Cnd=0, M_valA=0x29 -> imem_addr=0x29 same cycle.
4. W_icode=9, W_valM=0x55 together with M_icode=7, M_Cnd=0 -> imem_addr=M_valA (jXX priority). W alone -> 0x55.
5. D_stall=1 and D_bubble=1 for 2 cycles -> D outputs unchanged. Then D_bubble alone -> icode=1, rA=rB=F, stat=1.
6. Byte 0xC0 -> stat=4. imem_error=1 -> stat=3, icode=1. Byte 0x00 -> stat=2; with FETCH_HALT_HOLD_EN, f_predPC frozen for 5 further edges.
